// File: rtl/pc_gen.sv
// pc_gen: fetch-stage program counter with prioritised trap/branch redirects,
// start-up valid flag and a circular return-address stack for return prediction.
module pc_gen #(
    parameter int                 ADDR_W    = 32,
    parameter int                 STEP      = 1,
    parameter logic [ADDR_W-1:0]  RESET_VEC = '0,
    parameter int                 RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              trap_req,
    input  logic [ADDR_W-1:0] trap_vec,
    input  logic              branch_true,
    input  logic [ADDR_W-1:0] new_addr,
    input  logic              ras_push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic              ras_pop,
    output logic [ADDR_W-1:0] pc_output,
    output logic              pc_valid,
    output logic              ras_empty,
    output logic              ras_full,
    output logic              ras_underflow
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] ras [RAS_DEPTH];
    logic [PW-1:0]     top, top_nx, wr_ptr;
    logic [CW-1:0]     cnt, cnt_nx;
    logic [ADDR_W-1:0] pc_nx;
    logic              hint_ok, pop_hit, do_push;

    assign ras_empty = cnt == '0;
    assign ras_full  = cnt == CW'(RAS_DEPTH);

    always_comb begin
        hint_ok = pc_valid & ~trap_req & ~branch_true & ~stall;
        pop_hit = hint_ok & ras_pop & ~ras_empty;
        do_push = hint_ok & ras_push;
        // a push alongside a successful pop reuses the popped slot
        wr_ptr  = pop_hit ? top : top + PW'(1);
        pc_nx   = ~pc_valid ? pc_output : trap_req ? trap_vec : branch_true ? new_addr :
                  stall ? pc_output : pop_hit ? ras[top] : pc_output + ADDR_W'(STEP);
        cnt_nx  = ~pc_valid ? cnt : trap_req ? '0 :
                  pop_hit ? (do_push ? cnt : cnt - CW'(1)) :
                  do_push ? (ras_full ? cnt : cnt + CW'(1)) : cnt;
        top_nx  = pop_hit ? (do_push ? top : top - PW'(1)) : do_push ? top + PW'(1) : top;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_output     <= RESET_VEC;
            pc_valid      <= 1'b0;
            cnt           <= '0;
            top           <= '0;
            ras_underflow <= 1'b0;
        end else begin
            pc_output     <= pc_nx;
            pc_valid      <= 1'b1;
            cnt           <= cnt_nx;
            top           <= top_nx;
            ras_underflow <= hint_ok & ras_pop & ras_empty;
        end
    end

    always_ff @(posedge clk)
        if (!rst && do_push) ras[wr_ptr] <= push_addr;
endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the fetch stage. It supersedes the fixed-width, increment-by-one PC and adds several things: a configurable width, step and reset vector; prioritised trap and branch redirects; a start-up valid flag; and a small circular return-address stack (RAS) that predicts return targets from decode-stage call/return hints. It drives the instruction-fetch address and receives redirects from execute and the exception unit.

## Interface

Parameters:
- ADDR_W, 32, PC and address width in bits.
- STEP, 1, sequential increment added per advancing cycle (1 = word-addressed memory).
- RESET_VEC, 0, PC value loaded by reset.
- RAS_DEPTH, 4, return-address stack entries (power of two, ≥2).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold PC and ignore RAS hints.
- trap_req  in  1  exception/interrupt redirect.
- trap_vec  in  ADDR_W  trap target.
- branch_true  in  1  resolved-branch/jump redirect from execute.
- new_addr  in  ADDR_W  branch target.
- ras_push  in  1  decode saw a call; push push_addr.
- push_addr  in  ADDR_W  return address to push.
- ras_pop  in  1  decode saw a return; redirect to RAS top.
- pc_output  out  ADDR_W  current fetch address (registered).
- pc_valid  out  1  fetch address is valid (registered).
- ras_empty  out  1  RAS count == 0 (combinational from count).
- ras_full  out  1  RAS count == RAS_DEPTH.
- ras_underflow  out  1  one-cycle pulse: pop attempted on empty RAS.

## Operation

- Reset (rst=1 at edge) sets the following: pc_output=RESET_VEC, pc_valid=0, RAS count=0, top pointer=0, ras_underflow=0. RAS entry contents are don't-care.
- Start-up: the first non-reset edge sets pc_valid=1 and leaves pc_output at RESET_VEC. While pc_valid=0 the PC never advances or redirects, and all inputs are ignored.
- Next-PC priority, highest first, applies once pc_valid=1:
  1. trap_req: pc ← trap_vec. The RAS is cleared (count=0), and push/pop that cycle are ignored.
  2. branch_true: pc ← new_addr. The RAS is unchanged, and push/pop that cycle are ignored as wrong-path.
  3. stall: pc holds and push/pop are ignored.
  4. ras_pop with count>0: pc ← RAS top, and count decrements. If ras_push is also asserted, push_addr replaces the popped slot and count stays unchanged.
  5. ras_pop with count=0: ras_underflow=1 for one cycle and pc ← pc+STEP. A simultaneous push still occurs.
  6. Otherwise pc ← pc+STEP, and a lone ras_push pushes.
- trap_req and branch_true both override stall, so a redirect is never lost.
- Push semantics: the top pointer increments modulo RAS_DEPTH, push_addr is written there, and count saturates at RAS_DEPTH. A push when full overwrites the oldest entry.
- Pop semantics: the entry at the top pointer is read, then the top pointer decrements modulo RAS_DEPTH.
- Arithmetic: pc+STEP is truncated to ADDR_W bits, so the address wraps, for example 0xFFFF_FFFF+1 → 0x0000_0000.

## Timing

- All redirects and increments take effect at the next rising edge, giving 1-cycle latency. Outputs are never combinational from trap/branch/pop inputs.
- ras_underflow is registered and high for exactly the cycle after the offending pop.
- ras_empty and ras_full reflect the registered count, so they update one edge after a push or pop.
- Reset asserted mid-operation overrides every other input at that edge, including trap.
- Back-to-back redirects on consecutive cycles are each honoured. No bubble is inserted by this block.

## Test plan

- Reset/start-up: RESET_VEC=0x100, STEP=4; hold rst 3 cycles, release. pc_output must read 0x100 with pc_valid=0, then 0x100 with pc_valid=1, then 0x104, 0x108.
- Priority with stall: stall=1, branch_true=1, new_addr=0x40, and trap_req=1 with trap_vec=0x8 in the same cycle. Next pc must be 0x8 and ras_empty=1. Then stall=1 with branch only (new_addr=0x40): next pc must be 0x40. Then stall alone: pc must hold at 0x40.
- RAS call/return: push 0x10, 0x20, 0x30 on successive cycles, then pop three times. The redirected PCs must be 0x30, 0x20, 0x10 in turn, and ras_empty must be 1 afterwards.
- RAS overflow and underflow: RAS_DEPTH=4; push 0x1..0x5 (ras_full=1), then pop 5 times. The redirects must be 0x5, 0x4, 0x3, 0x2. The fifth pop must give pc+STEP with ras_underflow pulsing for 1 cycle.
- Simultaneous push and pop: with RAS holding {0xA, 0xB}, assert pop with push_addr=0xC. pc must become 0xB, count must stay 2, and the next pop must yield 0xC.
- Wrap-around: ADDR_W=8, STEP=1, branch to 0xFF. The next two PCs must be 0x00 and 0x01.
